// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : decode_queue
// Purpose  : Circular FIFO of fetched instructions (word + next-PC) placed
//            between Fetch and Issue. Fetch pushes with a valid/ready
//            handshake, Issue pops the head with a valid/ready handshake.
//            The head entry is decoded combinationally for Issue. A
//            synchronous flush empties the queue on a redirect.
// Ports    : clock, reset (async, active-low)
//            if_id_valid/if_id_instruc/if_id_nextpc -> push side, id_if_ready
//            flush                                  -> discard all entries
//            id_iss_valid, iss_ready                -> pop handshake
//            id_iss_instruc/nextpc/op/funct/addra/addrb/regdest/imedext
//                                                   -> decoded head entry
//            id_iss_count                           -> current occupancy
// Revision : 1.0 - initial release
// ============================================================================
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_id_valid,
  input  logic [31:0]      if_id_instruc,
  input  logic [PC_W-1:0]  if_id_nextpc,
  output logic             id_if_ready,
  input  logic             flush,
  output logic             id_iss_valid,
  input  logic             iss_ready,
  output logic [31:0]      id_iss_instruc,
  output logic [PC_W-1:0]  id_iss_nextpc,
  output logic [5:0]       id_iss_op,
  output logic [5:0]       id_iss_funct,
  output logic [4:0]       id_iss_addra,
  output logic [4:0]       id_iss_addrb,
  output logic [4:0]       id_iss_regdest,
  output logic [31:0]      id_iss_imedext,
  output logic [CNT_W-1:0] id_iss_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);

  logic [31:0]      instr_mem_q [DEPTH];
  logic [PC_W-1:0]  pc_mem_q    [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic w_push;
  logic w_pop;
  logic [31:0] w_head;

  // Full blocks a push even when a pop happens in the same cycle, so the
  // ready path never depends on iss_ready.
  assign id_if_ready  = (count_q != c_full_cnt);
  assign id_iss_valid = (count_q != '0);
  assign id_iss_count = count_q;

  assign w_push = if_id_valid & id_if_ready;
  assign w_pop  = id_iss_valid & iss_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + c_ptr_one;
      if (w_pop)  rd_ptr_d = rd_ptr_q + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      // A push in a flush cycle is discarded, so storage is left untouched.
      if (w_push && !flush) begin
        instr_mem_q[wr_ptr_q] <= if_id_instruc;
        pc_mem_q[wr_ptr_q]    <= if_id_nextpc;
      end
    end
  end

  // Empty queue presents zeros rather than stale storage; every decoded
  // field is derived from this gated word so they all read 0 when empty.
  always_comb begin
    w_head        = '0;
    id_iss_nextpc = '0;
    if (id_iss_valid) begin
      w_head        = instr_mem_q[rd_ptr_q];
      id_iss_nextpc = pc_mem_q[rd_ptr_q];
    end
  end

  assign id_iss_instruc = w_head;
  assign id_iss_op      = w_head[31:26];
  assign id_iss_funct   = w_head[5:0];
  assign id_iss_addra   = w_head[25:21];
  assign id_iss_addrb   = w_head[20:16];

  always_comb begin
    id_iss_regdest = w_head[20:16];
    id_iss_imedext = {{16{w_head[15]}}, w_head[15:0]};
    case (w_head[31:26])
      6'h00:   id_iss_regdest = w_head[15:11];
      6'h03:   id_iss_regdest = 5'd31;
      default: id_iss_regdest = w_head[20:16];
    endcase
    // Logical immediates (andi/ori/xori) are zero-extended.
    if (w_head[31:26] == 6'h0C || w_head[31:26] == 6'h0D ||
        w_head[31:26] == 6'h0E)
      id_iss_imedext = {16'h0000, w_head[15:0]};
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_queue
// Purpose  : Self-checking bench for decode_queue. A queue of expected
//            entries is kept in step with accepted pushes and pops; the head
//            outputs and handshakes are compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clock;
  logic             reset;
  logic             if_id_valid;
  logic [31:0]      if_id_instruc;
  logic [PC_W-1:0]  if_id_nextpc;
  logic             id_if_ready;
  logic             flush;
  logic             id_iss_valid;
  logic             iss_ready;
  logic [31:0]      id_iss_instruc;
  logic [PC_W-1:0]  id_iss_nextpc;
  logic [5:0]       id_iss_op;
  logic [5:0]       id_iss_funct;
  logic [4:0]       id_iss_addra;
  logic [4:0]       id_iss_addrb;
  logic [4:0]       id_iss_regdest;
  logic [31:0]      id_iss_imedext;
  logic [CNT_W-1:0] id_iss_count;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) u_dut (
    .clock          (clock),
    .reset          (reset),
    .if_id_valid    (if_id_valid),
    .if_id_instruc  (if_id_instruc),
    .if_id_nextpc   (if_id_nextpc),
    .id_if_ready    (id_if_ready),
    .flush          (flush),
    .id_iss_valid   (id_iss_valid),
    .iss_ready      (iss_ready),
    .id_iss_instruc (id_iss_instruc),
    .id_iss_nextpc  (id_iss_nextpc),
    .id_iss_op      (id_iss_op),
    .id_iss_funct   (id_iss_funct),
    .id_iss_addra   (id_iss_addra),
    .id_iss_addrb   (id_iss_addrb),
    .id_iss_regdest (id_iss_regdest),
    .id_iss_imedext (id_iss_imedext),
    .id_iss_count   (id_iss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  logic [63:0] sb [$];   // {instr, nextpc} in expected issue order

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Independent reference decode of a head word.
  function automatic logic [4:0] ref_rd(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    if (op == 6'h00)      return w[15:11];
    else if (op == 6'h03) return 5'd31;
    else                  return w[20:16];
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return {16'h0, w[15:0]};
    return {{16{w[15]}}, w[15:0]};
  endfunction

  task automatic check_outputs();
    logic [31:0] ei;
    logic [31:0] ep;
    ei = 32'h0;
    ep = 32'h0;
    if (sb.size() != 0) begin
      ei = sb[0][63:32];
      ep = sb[0][31:0];
    end
    chk("valid", 64'(id_iss_valid), 64'(sb.size() != 0));
    chk("ready", 64'(id_if_ready),  64'(sb.size() != DEPTH));
    chk("count", 64'(id_iss_count), 64'(sb.size()));
    chk("instr", 64'(id_iss_instruc), 64'(ei));
    chk("nextpc", 64'(id_iss_nextpc), 64'(ep));
    chk("op", 64'(id_iss_op), 64'(ei[31:26]));
    chk("funct", 64'(id_iss_funct), 64'(ei[5:0]));
    chk("addra", 64'(id_iss_addra), 64'(ei[25:21]));
    chk("addrb", 64'(id_iss_addrb), 64'(ei[20:16]));
    chk("regdest", 64'(id_iss_regdest), 64'(ref_rd(ei)));
    chk("imedext", 64'(id_iss_imedext), 64'(ref_imm(ei)));
  endtask

  // One clock of stimulus: check current outputs, drive, update scoreboard
  // at the edge, then leave inputs idle just after the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                      input logic rdy, input logic fl);
    logic exp_push;
    logic exp_pop;
    @(negedge clock);
    check_outputs();
    if_id_valid   = v;
    if_id_instruc = ins;
    if_id_nextpc  = pc;
    iss_ready     = rdy;
    flush         = fl;
    exp_push = v && (sb.size() < DEPTH);
    exp_pop  = rdy && (sb.size() != 0);
    @(posedge clock);
    if (fl) sb.delete();
    else begin
      if (exp_pop)  void'(sb.pop_front());
      if (exp_push) sb.push_back({ins, pc});
    end
    #1;
    if_id_valid = 1'b0;
    iss_ready   = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    if_id_valid = 1'b0;
    if_id_instruc = '0;
    if_id_nextpc = '0;
    iss_ready = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;

    // Reset / idle state
    idle();
    chk("rst_valid", 64'(id_iss_valid), 64'd0);
    chk("rst_ready", 64'(id_if_ready), 64'd1);
    chk("rst_count", 64'(id_iss_count), 64'd0);
    chk("rst_regdest", 64'(id_iss_regdest), 64'd0);
    chk("rst_imedext", 64'(id_iss_imedext), 64'd0);

    // Single R-type push, visible after one edge
    step(1'b1, 32'h012A4020, 32'h00400004, 1'b0, 1'b0);
    chk("add_valid", 64'(id_iss_valid), 64'd1);
    chk("add_count", 64'(id_iss_count), 64'd1);
    chk("add_regdest", 64'(id_iss_regdest), 64'd8);
    chk("add_addra", 64'(id_iss_addra), 64'd9);
    chk("add_addrb", 64'(id_iss_addrb), 64'd10);
    chk("add_op", 64'(id_iss_op), 64'd0);
    chk("add_funct", 64'(id_iss_funct), 64'h20);
    chk("add_nextpc", 64'(id_iss_nextpc), 64'h00400004);
    step(1'b0, 32'h0, '0, 1'b1, 1'b0);   // drain
    idle();

    // Fill beyond capacity; 5th entry held until a pop frees a slot
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h20010000 + 32'(i), 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
    chk("full_ready", 64'(id_if_ready), 64'd0);
    chk("full_count", 64'(id_iss_count), 64'd4);
    step(1'b1, 32'h20010004, 32'h1010, 1'b0, 1'b0);   // held
    chk("held_count", 64'(id_iss_count), 64'd4);
    step(1'b1, 32'h20010004, 32'h1010, 1'b1, 1'b0);   // pop only
    chk("pop_full_count", 64'(id_iss_count), 64'd3);
    step(1'b1, 32'h20010004, 32'h1010, 1'b0, 1'b0);   // accepted
    chk("refill_count", 64'(id_iss_count), 64'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, '0, 1'b1, 1'b0);
    idle();

    // Immediate extension and jal destination
    step(1'b1, 32'h3508FFFF, 32'h2004, 1'b0, 1'b0);
    chk("ori_imm", 64'(id_iss_imedext), 64'h0000FFFF);
    chk("ori_rd", 64'(id_iss_regdest), 64'd8);
    step(1'b1, 32'h2108FFFF, 32'h2008, 1'b1, 1'b0);
    chk("addi_imm", 64'(id_iss_imedext), 64'hFFFFFFFF);
    step(1'b1, 32'h0C100000, 32'h200C, 1'b1, 1'b0);
    chk("jal_rd", 64'(id_iss_regdest), 64'd31);
    step(1'b0, 32'h0, '0, 1'b1, 1'b0);
    idle();

    // Steady push+pop, pointers wrap
    step(1'b1, 32'h00221820, 32'h3000, 1'b1, 1'b0);
    for (int i = 1; i < 2 * DEPTH + 3; i++) begin
      step(1'b1, 32'h30000000 + ($urandom & 32'h03FF_FFFF) , 32'h3000 + 32'(4 * i), 1'b1, 1'b0);
      chk("steady_count", 64'(id_iss_count), 64'd1);
    end
    step(1'b0, 32'h0, '0, 1'b1, 1'b0);
    idle();

    // Flush with same-cycle push and pop
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h24420000 + 32'(i), 32'h4000 + 32'(4 * i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD0001, 32'h4FFC, 1'b1, 1'b1);
    chk("flush_count", 64'(id_iss_count), 64'd0);
    chk("flush_valid", 64'(id_iss_valid), 64'd0);
    step(1'b1, 32'h012A4020, 32'h5000, 1'b0, 1'b0);
    chk("post_flush_head", 64'(id_iss_instruc), 64'h012A4020);
    step(1'b0, 32'h0, '0, 1'b1, 1'b0);
    idle();

    // Asynchronous reset mid-fill
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h8C880000 + 32'(i), 32'h6000 + 32'(4 * i), 1'b0, 1'b0);
    chk("pre_rst_count", 64'(id_iss_count), 64'd3);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_count", 64'(id_iss_count), 64'd0);
    chk("async_rst_valid", 64'(id_iss_valid), 64'd0);
    chk("async_rst_instr", 64'(id_iss_instruc), 64'd0);
    sb.delete();
    @(negedge clock);
    #1 reset = 1'b1;
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the single-register decode latch.
- Sits between Fetch and Issue and holds up to DEPTH fetched instructions (instruction word plus next-PC) in a circular FIFO.
- Fetch and Issue are decoupled by valid/ready handshakes, so an issue stall no longer freezes fetch until the queue fills.
- Head-of-queue fields are decoded and presented to Issue, with a synchronous flush for branch/jump redirects.

Parameters:
DEPTH, 4, number of queue entries; power of two, >= 2
PC_W, 32, width of stored next-PC
CNT_W, $clog2(DEPTH)+1, width of occupancy count

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
if_id_valid  input  1  Fetch presents an instruction this cycle
if_id_instruc  input  32  fetched instruction word
if_id_nextpc  input  PC_W  PC+4 of fetched instruction
id_if_ready  output  1  queue accepts a push this cycle
flush  input  1  discard all queued entries (redirect)
id_iss_valid  output  1  head entry valid
iss_ready  input  1  Issue consumes head this cycle
id_iss_instruc  output  32  head instruction word
id_iss_nextpc  output  PC_W  head next-PC
id_iss_op  output  6  head instr[31:26]
id_iss_funct  output  6  head instr[5:0]
id_iss_addra  output  5  head instr[25:21]
id_iss_addrb  output  5  head instr[20:16]
id_iss_regdest  output  5  decoded destination register
id_iss_imedext  output  32  extended immediate
id_iss_count  output  CNT_W  current occupancy

Behaviour:
- Reset (reset=0, asynchronous):
  - Read pointer, write pointer and count are set to 0.
  - Storage is cleared to 0.
  - id_iss_valid=0, id_if_ready=1, id_iss_count=0.
  - All id_iss data outputs are 0.
  - Reset asserted mid-operation drops every entry immediately, with no partial pop.
- Push:
  - Occurs when if_id_valid & id_if_ready at a rising edge.
  - The entry is written at the write pointer, and the write pointer increments modulo DEPTH (natural wrap).
- Pop:
  - Occurs when id_iss_valid & iss_ready at a rising edge.
  - The read pointer increments modulo DEPTH.
- Ready/valid:
  - id_if_ready = (count != DEPTH). There is no push-through-full, even if a pop happens in the same cycle.
  - id_iss_valid = (count != 0).
- Latency: 1 cycle. A push at edge N is visible at the head after edge N when the queue was empty. There is no combinational fall-through from if_id_* to id_iss_*.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Count update: count += push - pop. It never exceeds DEPTH and never goes below 0.
- Flush (synchronous, highest priority):
  - At the edge, pointers and count go to 0.
  - A same-cycle push is discarded and a same-cycle pop has no effect.
  - The next cycle id_iss_valid=0.
- Empty queue: all id_iss data outputs are forced to 0, never stale storage.
- Head decode (combinational from the head entry):
  - regdest = instr[15:11] if op==6'h00 (R-type); 5'd31 if op==6'h03 (jal); otherwise instr[20:16].
  - imedext is zero-extended ({16'h0, instr[15:0]}) for op 6'h0C, 6'h0D, 6'h0E (andi/ori/xori).
  - imedext is sign-extended for all other ops.
  - addra, addrb, op and funct are pure bit slices of the head instruction.
- id_iss_instruc and id_iss_nextpc present the head entry verbatim.
- Fetch obligation: Fetch holds if_id_* stable while if_id_valid & ~id_if_ready. The queue never drops or overwrites an entry.

Test Plan:
- Reset then idle -> id_iss_valid=0, id_if_ready=1, count=0, regdest=0, imedext=0; assert reset mid-fill (count=3) -> count=0 at once, valid=0.
- Push 0x012A4020 (add $8,$9,$10), nextpc 0x00400004, iss_ready=0 -> next cycle valid=1, count=1, regdest=8, addra=9, addrb=10, op=0, funct=0x20.
- Push 5 entries with DEPTH=4 and iss_ready=0 -> id_if_ready=0 after the 4th, count=4, 5th held; raise iss_ready for one cycle -> count=3, 5th accepted next edge, FIFO order preserved.
- Head 0x3508FFFF (ori $8,$8,0xFFFF) -> imedext=0x0000FFFF, regdest=8; head 0x2108FFFF (addi) -> imedext=0xFFFFFFFF; head 0x0C100000 (jal) -> regdest=31.
- Steady push+pop every cycle for 2*DEPTH+3 instructions -> count stays 1, pointers wrap, outputs match the input sequence delayed 1 cycle.
- count=3 with flush, if_id_valid=1 and iss_ready=1 in the same cycle -> count=0, valid=0 next cycle, flushed push absent from subsequent output.
